// File: rtl/menu_pkg.sv
// menu_pkg: shared mode encoding, button indices and width helper for the
// menu navigation controller.
package menu_pkg;

  // Controller modes as seen on the mode output.
  typedef enum logic [1:0] {
    BROWSE = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } mode_t;

  // Button indices, listed from highest to lowest priority.
  localparam int BTN_BACK = 0;
  localparam int BTN_SEL  = 1;
  localparam int BTN_UP   = 2;
  localparam int BTN_DOWN = 3;
  localparam int NUM_BTNS = 4;

  // Index width for n items: max(1, clog2(n)).
  function automatic int idx_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_event_det.sv
// btn_event_det: 2-FF synchroniser plus rising-edge detector for one raw,
// externally debounced push-button. A raw high sampled at edge N produces
// a one-cycle event_pulse in the cycle after edge N+2. level is the
// synchronised button level.
module btn_event_det (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic event_pulse
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;

  // Synchroniser chain, previous-level register and registered edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Idle means "seen as already held": a button held through reset must
      // be released and pressed again before it can produce an event.
      sync_q1     <= 1'b1;
      sync_q2     <= 1'b1;
      prev_q      <= 1'b1;
      event_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's pre-edge value, giving a true shift chain.
      sync_q1     <= btn_raw;
      sync_q2     <= sync_q1;
      prev_q      <= sync_q2;
      event_pulse <= sync_q2 & ~prev_q;
    end
  end

  assign level = sync_q2;

endmodule

// File: rtl/menu_nav_controller.sv
// menu_nav_controller: turns four push-buttons into prioritised events and
// runs the browse/edit/commit sequencer that writes item values downstream
// over a valid/ready handshake.
// Build macro MENU_AUTOREPEAT_EN: when defined, holding up/down in BROWSE or
// EDIT generates repeat events after HOLD_CYCLES, then every REPEAT_CYCLES.
module menu_nav_controller
  import menu_pkg::*;
#(
  parameter int  NUM_ITEMS     = 4,
  parameter int  VAL_W         = 4,
  parameter int  MAX_VAL       = 15,
  parameter int  HOLD_CYCLES   = 50_000_000,
  parameter int  REPEAT_CYCLES = 10_000_000,
  localparam int IDX_W         = idx_width(NUM_ITEMS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  input  logic             btn_back,
  output logic [1:0]       mode,
  output logic [IDX_W-1:0] item_idx,
  output logic [VAL_W-1:0] edit_val,
  output logic             cfg_valid,
  output logic [IDX_W-1:0] cfg_addr,
  output logic [VAL_W-1:0] cfg_data,
  input  logic             cfg_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ITEMS - 1);
  localparam logic [VAL_W-1:0] MAX_V    = VAL_W'(MAX_VAL);

  // Reject parameter sets the datapath cannot represent.
  if (NUM_ITEMS < 2 || MAX_VAL < 0 || MAX_VAL > (2 ** VAL_W) - 1 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 || REPEAT_CYCLES > HOLD_CYCLES)
  begin : g_param_check
    $error("menu_nav_controller: illegal parameter combination");
  end

  // ---------------------------------------------------------------------
  // Button event generation
  // ---------------------------------------------------------------------
  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_evt;

  assign btn_raw[BTN_BACK] = btn_back;
  assign btn_raw[BTN_SEL]  = btn_sel;
  assign btn_raw[BTN_UP]   = btn_up;
  assign btn_raw[BTN_DOWN] = btn_down;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_det
    btn_event_det u_det (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .level      (btn_level[i]),
      .event_pulse(btn_press[i])
    );
  end

  // ---------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------
  mode_t            mode_q, mode_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [IDX_W-1:0] addr_q, addr_n;
  logic [VAL_W-1:0] edit_q, edit_n;
  logic [VAL_W-1:0] data_q, data_n;
  logic             valid_q, valid_n;
  logic             shadow_we;
  logic [VAL_W-1:0] shadow_q [NUM_ITEMS];

`ifdef MENU_AUTOREPEAT_EN
  // ---------------------------------------------------------------------
  // Auto-repeat for up/down
  // ---------------------------------------------------------------------
  localparam int               CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES + 1);

  logic [NUM_BTNS-1:0] rpt_evt;
  logic                unused_level;

  for (genvar i = 0; i < 2; i++) begin : g_rpt
    localparam int B = (i == 0) ? BTN_UP : BTN_DOWN;
    logic [CNT_W-1:0] hold_cnt;

    // Hold counter: starts at the press event, reloads after each repeat so
    // the next one lands REPEAT_CYCLES later, clears on release, reset, any
    // mode change and throughout COMMIT.
    always_ff @(posedge clk) begin
      if (reset || !btn_level[B] || (mode_n != mode_q) || (mode_q == COMMIT)) begin
        hold_cnt <= '0;
      end else if (btn_press[B]) begin
        hold_cnt <= CNT_W'(1);
      end else if (hold_cnt == HOLD_C) begin
        hold_cnt <= RELOAD_C;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end

    assign rpt_evt[B] = btn_level[B] && (hold_cnt == HOLD_C) && (mode_q != COMMIT);
  end

  assign rpt_evt[BTN_BACK] = 1'b0;
  assign rpt_evt[BTN_SEL]  = 1'b0;
  assign btn_evt           = btn_press | rpt_evt;
  // back/sel levels have no consumer.
  assign unused_level      = btn_level[BTN_BACK] ^ btn_level[BTN_SEL];
`else
  logic unused_level;

  assign btn_evt      = btn_press;
  // Levels only feed the auto-repeat counters, absent in this build.
  assign unused_level = ^btn_level;
`endif

  // Next-state logic: one prioritised event per cycle (back > sel > up > down).
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if chain can leave one unassigned and infer a latch.
    mode_n    = mode_q;
    idx_n     = idx_q;
    edit_n    = edit_q;
    valid_n   = valid_q;
    addr_n    = addr_q;
    data_n    = data_q;
    shadow_we = 1'b0;

    case (mode_q)
      BROWSE: begin
        if (btn_evt[BTN_BACK]) begin
          // Nothing to leave; the event still masks lower priorities.
        end else if (btn_evt[BTN_SEL]) begin
          edit_n = shadow_q[idx_q];
          mode_n = EDIT;
        end else if (btn_evt[BTN_UP]) begin
          idx_n = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end else if (btn_evt[BTN_DOWN]) begin
          idx_n = (idx_q == '0) ? LAST_IDX : idx_q - IDX_W'(1);
        end
      end

      EDIT: begin
        if (btn_evt[BTN_BACK]) begin
          mode_n = BROWSE;
        end else if (btn_evt[BTN_SEL]) begin
          valid_n = 1'b1;
          addr_n  = idx_q;
          data_n  = edit_q;
          mode_n  = COMMIT;
        end else if (btn_evt[BTN_UP]) begin
          if (edit_q < MAX_V) edit_n = edit_q + VAL_W'(1);
        end else if (btn_evt[BTN_DOWN]) begin
          if (edit_q != '0) edit_n = edit_q - VAL_W'(1);
        end
      end

      COMMIT: begin
        // Request held until accepted; buttons are ignored meanwhile.
        if (valid_q && cfg_ready) begin
          valid_n   = 1'b0;
          shadow_we = 1'b1;
          mode_n    = BROWSE;
        end
      end

      default: mode_n = BROWSE;
    endcase
  end

  // State, request and shadow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= BROWSE;
      idx_q   <= '0;
      edit_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      // NOTE: the shadow array is small register storage that must read back
      // as zero after reset, so every entry is cleared explicitly.
      for (int i = 0; i < NUM_ITEMS; i++) shadow_q[i] <= '0;
    end else begin
      mode_q  <= mode_n;
      idx_q   <= idx_n;
      edit_q  <= edit_n;
      valid_q <= valid_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      if (shadow_we) shadow_q[addr_q] <= data_q;
    end
  end

  assign mode      = mode_q;
  assign item_idx  = idx_q;
  assign edit_val  = (mode_q == BROWSE) ? shadow_q[idx_q] : edit_q;
  assign cfg_valid = valid_q;
  assign cfg_addr  = addr_q;
  assign cfg_data  = data_q;

endmodule

// File: tb/tb_menu_nav_controller.sv
// tb_menu_nav_controller: directed scenarios plus randomized button traffic,
// every cycle compared against a behavioural model built from the menu rules
// (event = rising edge of the raw sample stream seen three edges earlier).
module tb_menu_nav_controller;

  localparam int NUM_ITEMS     = 4;
  localparam int VAL_W         = 4;
  localparam int MAX_VAL       = 15;
  localparam int HOLD_CYCLES   = 8;
  localparam int REPEAT_CYCLES = 4;
  localparam int IDX_W         = 2;

  localparam int K_BACK = 0, K_SEL = 1, K_UP = 2, K_DOWN = 3;
  localparam int M_BROWSE = 0, M_EDIT = 1, M_COMMIT = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_up, btn_down, btn_sel, btn_back;
  logic [1:0]       mode;
  logic [IDX_W-1:0] item_idx;
  logic [VAL_W-1:0] edit_val;
  logic             cfg_valid;
  logic [IDX_W-1:0] cfg_addr;
  logic [VAL_W-1:0] cfg_data;
  logic             cfg_ready;

  menu_nav_controller #(
    .NUM_ITEMS    (NUM_ITEMS),
    .VAL_W        (VAL_W),
    .MAX_VAL      (MAX_VAL),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_sel  (btn_sel),
    .btn_back (btn_back),
    .mode     (mode),
    .item_idx (item_idx),
    .edit_val (edit_val),
    .cfg_valid(cfg_valid),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_seen = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode, m_idx, m_edit, m_valid, m_addr, m_data;
  int m_shadow [NUM_ITEMS];
  // hist[b] bit k = raw sample of button b taken k edges ago (reset reads as held)
  bit [7:0] hist [4];
  int age [4];
  bit alive [4];

  task automatic model_edge();
    bit raw [4];
    bit ev [4];
    bit lvl;
    int old_mode;
    raw[K_BACK] = btn_back;
    raw[K_SEL]  = btn_sel;
    raw[K_UP]   = btn_up;
    raw[K_DOWN] = btn_down;
    for (int b = 0; b < 4; b++) hist[b] = {hist[b][6:0], (reset ? 1'b1 : raw[b])};
    if (reset) begin
      m_mode = M_BROWSE; m_idx = 0; m_edit = 0; m_valid = 0; m_addr = 0; m_data = 0;
      for (int i = 0; i < NUM_ITEMS; i++) m_shadow[i] = 0;
      for (int b = 0; b < 4; b++) alive[b] = 0;
      return;
    end
    for (int b = 0; b < 4; b++) ev[b] = hist[b][3] && !hist[b][4];
    old_mode = m_mode;
`ifdef MENU_AUTOREPEAT_EN
    for (int b = K_UP; b <= K_DOWN; b++) begin
      lvl = hist[b][2];
      if (alive[b]) age[b]++;
      if (alive[b] && lvl && m_mode != M_COMMIT && age[b] >= HOLD_CYCLES &&
          ((age[b] - HOLD_CYCLES) % REPEAT_CYCLES) == 0)
        ev[b] = 1'b1;
    end
`endif
    case (m_mode)
      M_BROWSE: begin
        if (ev[K_BACK]) ;
        else if (ev[K_SEL]) begin m_edit = m_shadow[m_idx]; m_mode = M_EDIT; end
        else if (ev[K_UP]) m_idx = (m_idx + 1) % NUM_ITEMS;
        else if (ev[K_DOWN]) m_idx = (m_idx + NUM_ITEMS - 1) % NUM_ITEMS;
      end
      M_EDIT: begin
        if (ev[K_BACK]) m_mode = M_BROWSE;
        else if (ev[K_SEL]) begin
          m_valid = 1; m_addr = m_idx; m_data = m_edit; m_mode = M_COMMIT;
        end
        else if (ev[K_UP]) m_edit = (m_edit + 1 > MAX_VAL) ? MAX_VAL : m_edit + 1;
        else if (ev[K_DOWN]) m_edit = (m_edit - 1 < 0) ? 0 : m_edit - 1;
      end
      default: begin
        if (cfg_ready) begin
          m_shadow[m_addr] = m_data; m_valid = 0; m_mode = M_BROWSE;
        end
      end
    endcase
`ifdef MENU_AUTOREPEAT_EN
    for (int b = K_UP; b <= K_DOWN; b++) begin
      lvl = hist[b][2];
      if (!lvl || m_mode != old_mode || old_mode == M_COMMIT) alive[b] = 0;
      else if (ev[b] && hist[b][3] && !hist[b][4]) begin alive[b] = 1; age[b] = 0; end
    end
`endif
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic tick();
    int exp_edit;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    exp_edit = (m_mode == M_BROWSE) ? m_shadow[m_idx] : m_edit;
    check($sformatf("mode c%0d", cyc), mode, m_mode);
    check($sformatf("item_idx c%0d", cyc), item_idx, m_idx);
    check($sformatf("edit_val c%0d", cyc), edit_val, exp_edit);
    check($sformatf("cfg_valid c%0d", cyc), cfg_valid, m_valid);
    check($sformatf("cfg_addr c%0d", cyc), cfg_addr, m_addr);
    check($sformatf("cfg_data c%0d", cyc), cfg_data, m_data);
    if (cfg_valid) valid_seen++;
  endtask

  task automatic set_btns(input bit [3:0] v);
    btn_back = v[K_BACK];
    btn_sel  = v[K_SEL];
    btn_up   = v[K_UP];
    btn_down = v[K_DOWN];
  endtask

  task automatic press(input int b, input int hi, input int lo);
    bit [3:0] v;
    v = '0;
    v[b] = 1'b1;
    set_btns(v);
    repeat (hi) tick();
    set_btns('0);
    repeat (lo) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
  endtask

  int up_exp [5];
  int wait_n;
  bit [3:0] rv;

  initial begin
    for (int b = 0; b < 4; b++) begin hist[b] = 8'hFF; alive[b] = 0; age[b] = 0; end
    set_btns('0);
    cfg_ready = 1'b1;
    reset     = 1'b1;

    // Reset state
    do_reset();
    tick();
    check("rst mode", mode, M_BROWSE);
    check("rst item_idx", item_idx, 0);
    check("rst edit_val", edit_val, 0);
    check("rst cfg_valid", cfg_valid, 0);

    // Up five times: 1,2,3,0,1
    up_exp = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      press(K_UP, 3, 3);
      check($sformatf("up seq %0d", i), item_idx, up_exp[i]);
    end
    press(K_DOWN, 3, 3);
    check("down to 0", item_idx, 0);
    // Latency: sampled at edge N, visible only after edge N+3
    btn_down = 1'b1;
    repeat (3) tick();
    check("latency early", item_idx, 0);
    btn_down = 1'b0;
    tick();
    check("down wrap", item_idx, 3);
    repeat (3) tick();

    // Button held through reset gives no event until re-pressed
    btn_up = 1'b1;
    do_reset();
    repeat (8) tick();
    check("held through reset", item_idx, 0);
    btn_up = 1'b0;
    repeat (3) tick();
    press(K_UP, 3, 3);
    check("press after reset", item_idx, 1);

    // Edit item 2 to saturation, commit with delayed ready
    press(K_UP, 3, 3);
    check("at item 2", item_idx, 2);
    press(K_SEL, 3, 3);
    check("enter edit", mode, M_EDIT);
    for (int i = 0; i < 20; i++) press(K_UP, 2, 2);
    check("edit saturates", edit_val, MAX_VAL);
    cfg_ready  = 1'b0;
    valid_seen = 0;
    press(K_SEL, 3, 0);
    wait_n = 0;
    while (!cfg_valid && wait_n < 10) begin tick(); wait_n++; end
    check("commit request seen", cfg_valid, 1);
    check("commit addr", cfg_addr, 2);
    check("commit data", cfg_data, 15);
    btn_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) btn_up = 1'b0;
      tick();
    end
    cfg_ready = 1'b1;
    tick();
    check("valid cycles", valid_seen, 6);
    repeat (6) tick();
    check("commit back to browse", mode, M_BROWSE);
    check("shadow[2] written", edit_val, 15);
    check("up ignored in commit", item_idx, 2);

    // Edit item 1 and abandon it
    valid_seen = 0;
    press(K_DOWN, 3, 3);
    press(K_SEL, 3, 3);
    for (int i = 0; i < 3; i++) press(K_UP, 3, 3);
    check("edit item 1", edit_val, 3);
    press(K_BACK, 3, 3);
    check("back mode", mode, M_BROWSE);
    check("shadow[1] kept", edit_val, 0);
    check("no request on back", valid_seen, 0);

    // up and back in the same cycle while editing: back wins
    press(K_SEL, 3, 3);
    press(K_UP, 3, 3);
    check("edit before prio", edit_val, 1);
    btn_up = 1'b1; btn_back = 1'b1;
    repeat (3) tick();
    set_btns('0);
    repeat (3) tick();
    check("prio mode", mode, M_BROWSE);
    check("prio edit_val", edit_val, 0);

    // Long hold of up from item 0
    do_reset();
    repeat (3) tick();
    btn_up = 1'b1;
    repeat (30) tick();
    btn_up = 1'b0;
    repeat (10) tick();
`ifdef MENU_AUTOREPEAT_EN
    check("long hold", item_idx, 3);
`else
    check("long hold", item_idx, 1);
`endif

    // Randomized traffic
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      rv = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) rv = 4'(1 << $urandom_range(0, 3));
      set_btns(rv);
      for (int t = $urandom_range(1, 14); t > 0; t--) begin
        cfg_ready = $urandom_range(0, 1) == 1;
        tick();
      end
      set_btns('0);
      for (int t = $urandom_range(1, 4); t > 0; t--) begin
        cfg_ready = $urandom_range(0, 1) == 1;
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
